// File: rtl/mips_debug_pkg.sv
// rtl/mips_debug_pkg.sv - shared command bytes, state encodings and sizing helpers for the debug unit
package mips_debug_pkg;

    localparam logic [7:0] CMD_RESET = 8'h52;
    localparam logic [7:0] CMD_CONT  = 8'h43;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_DUMP  = 8'h44;
    localparam logic [7:0] CMD_PAUSE = 8'h50;

    localparam int DEFAULT_LEN    = 32;
    localparam int BYTES_PER_WORD = DEFAULT_LEN / 8;

    function automatic int bytes_per_word(input int len);
        return len / 8;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RSTM,
        ST_RUN,
        ST_STEP,
        ST_DUMP_ADDR,
        ST_DUMP_LOAD,
        ST_DUMP_XMIT
    } dbg_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SEND,
        SER_WAIT
    } ser_state_t;

endpackage

// File: rtl/mips_debug_unit_tx_serializer.sv
// rtl/mips_debug_unit_tx_serializer.sv - word-to-byte shift register with tx_start/tx_done handshake
module debug_tx_serializer
    import mips_debug_pkg::*;
#(
    parameter int LEN = 8 * BYTES_PER_WORD
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [LEN-1:0] word,
    input  logic           tx_done,
    output logic           tx_start,
    output logic [7:0]     data_out,
    output logic           done
);
    localparam int BPW = bytes_per_word(LEN);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    ser_state_t     state, state_next;
    logic [LEN-1:0] shreg, shreg_next, shreg_shifted;
    logic [CW-1:0]  left, left_next;
    logic           tx_start_next;
    logic [7:0]     data_out_next;

    assign shreg_shifted = shreg >> 8;

    // tx_done is only honoured in WAIT, so a stray pulse while the byte is
    // still being launched (SEND) or between words (IDLE) cannot skip a byte.
    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        left_next     = left;
        tx_start_next = 1'b0;
        data_out_next = data_out;
        done          = 1'b0;
        case (state)
            SER_IDLE: begin
                if (load) begin
                    shreg_next    = word;
                    data_out_next = word[7:0];
                    tx_start_next = 1'b1;
                    left_next     = CW'(BPW - 1);
                    state_next    = SER_SEND;
                end
            end
            SER_SEND: state_next = SER_WAIT;
            SER_WAIT: begin
                if (tx_done) begin
                    if (left == '0) begin
                        done       = 1'b1;
                        state_next = SER_IDLE;
                    end else begin
                        shreg_next    = shreg_shifted;
                        data_out_next = shreg_shifted[7:0];
                        tx_start_next = 1'b1;
                        left_next     = left - 1'b1;
                        state_next    = SER_SEND;
                    end
                end
            end
            default: state_next = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SER_IDLE;
            shreg    <= '0;
            left     <= '0;
            tx_start <= 1'b0;
            data_out <= 8'h00;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            left     <= left_next;
            tx_start <= tx_start_next;
            data_out <= data_out_next;
        end
    end

endmodule

// File: rtl/mips_debug_unit.sv
// rtl/mips_debug_unit.sv - UART debug controller: command decode, pipeline enable and snapshot dump
module mips_debug_unit
    import mips_debug_pkg::*;
#(
    parameter int LEN     = 32,
    parameter int N_WORDS = 64,
    parameter int NA      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx_done,
    input  logic [7:0]     uart_data_in,
    input  logic           tx_done,
    output logic           tx_start,
    output logic [7:0]     uart_data_out,
    input  logic           halt,
    output logic [NA-1:0]  dump_addr,
    input  logic [LEN-1:0] dump_data,
    output logic           mips_enable,
    output logic           reset_mips,
    output logic           busy
);
    localparam int WW = $clog2(N_WORDS + 1);

    dbg_state_t     state, state_next;
    logic           rstm_second;
    logic           rst_hold;
    logic [WW-1:0]  widx, widx_next;
    logic [LEN-1:0] cycle_cnt;
    logic [LEN-1:0] load_word;
    logic           ser_load;
    logic           ser_done;

    // Word 0 of every dump is the cycle counter; the rest come from the snapshot port.
    assign load_word = (widx == '0) ? cycle_cnt : dump_data;

    always_comb begin
        state_next = state;
        widx_next  = widx;
        ser_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                widx_next = '0;
                if (rx_done) begin
                    case (uart_data_in)
                        CMD_RESET: state_next = ST_RSTM;
                        CMD_CONT:  state_next = halt ? ST_DUMP_ADDR : ST_RUN;
                        CMD_STEP:  state_next = halt ? ST_DUMP_ADDR : ST_STEP;
                        CMD_DUMP:  state_next = ST_DUMP_ADDR;
                        default:   state_next = ST_IDLE;
                    endcase
                end
            end
            ST_RSTM: begin
                if (rstm_second) state_next = ST_IDLE;
            end
            ST_RUN: begin
                if (halt || (rx_done && uart_data_in == CMD_PAUSE)) state_next = ST_DUMP_ADDR;
            end
            ST_STEP:      state_next = ST_DUMP_ADDR;
            ST_DUMP_ADDR: state_next = ST_DUMP_LOAD;
            ST_DUMP_LOAD: begin
                ser_load   = 1'b1;
                state_next = ST_DUMP_XMIT;
            end
            ST_DUMP_XMIT: begin
                if (ser_done) begin
                    if (widx == WW'(N_WORDS)) begin
                        state_next = ST_IDLE;
                    end else begin
                        widx_next  = widx + 1'b1;
                        state_next = ST_DUMP_ADDR;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from state_next so a command seen in cycle t
    // takes effect in cycle t+1; rst_hold stretches reset_mips one cycle past reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            rstm_second <= 1'b0;
            rst_hold    <= 1'b1;
            widx        <= '0;
            dump_addr   <= '0;
            cycle_cnt   <= '0;
            mips_enable <= 1'b0;
            reset_mips  <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            widx        <= widx_next;
            rstm_second <= (state == ST_RSTM);
            rst_hold    <= 1'b0;
            reset_mips  <= rst_hold || (state_next == ST_RSTM);
            mips_enable <= (state_next == ST_RUN) || (state_next == ST_STEP);
            busy        <= (state_next != ST_IDLE);
            if (state == ST_DUMP_ADDR)
                dump_addr <= (widx == '0) ? '0 : NA'(widx - 1'b1);
            if (state == ST_RSTM)
                cycle_cnt <= '0;
            else if (mips_enable && cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    debug_tx_serializer #(
        .LEN(LEN)
    ) u_tx_serializer (
        .clk      (clk),
        .reset    (reset),
        .load     (ser_load),
        .word     (load_word),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .data_out (uart_data_out),
        .done     (ser_done)
    );

endmodule

// File: tb/tb_mips_debug_unit.sv
// tb/tb_mips_debug_unit.sv - scoreboard bench for mips_debug_unit with a 10-cycle uart model
module tb_mips_debug_unit;
    localparam int LEN     = 32;
    localparam int N_WORDS = 4;
    localparam int NA      = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           rx_done = 1'b0;
    logic [7:0]     uart_data_in = 8'h00;
    logic           tx_done = 1'b0;
    logic           tx_start;
    logic [7:0]     uart_data_out;
    logic           halt = 1'b0;
    logic [NA-1:0]  dump_addr;
    logic [LEN-1:0] dump_data;
    logic           mips_enable;
    logic           reset_mips;
    logic           busy;

    int   total = 0;
    int   bad = 0;
    int   n_start = 0;
    int   en_cycles = 0;
    int   dump_bytes = 0;
    int   uart_cnt = 0;
    bit   data_mode = 1'b0;
    bit   spur_arm = 1'b0;
    bit   was_done = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign dump_data = data_mode ? (32'hA0B0C0D0 | 32'(dump_addr)) : 32'h11223344;

    mips_debug_unit #(.LEN(LEN), .N_WORDS(N_WORDS), .NA(NA)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_done       (rx_done),
        .uart_data_in  (uart_data_in),
        .tx_done       (tx_done),
        .tx_start      (tx_start),
        .uart_data_out (uart_data_out),
        .halt          (halt),
        .dump_addr     (dump_addr),
        .dump_data     (dump_data),
        .mips_enable   (mips_enable),
        .reset_mips    (reset_mips),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        rx_done = 1'b1;
        uart_data_in = b;
        @(negedge clk);
        rx_done = 1'b0;
        uart_data_in = 8'h00;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
    endtask

    task automatic push_dump(input logic [31:0] cnt);
        push_word(cnt);
        for (int k = 0; k < N_WORDS; k++)
            push_word(data_mode ? (32'hA0B0C0D0 | 32'(k)) : 32'h11223344);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    // uart model plus output monitor: pops the expected byte on every tx_start
    initial begin
        forever begin
            @(negedge clk);
            if (mips_enable) en_cycles++;
            tx_done = 1'b0;
            if (reset) begin
                uart_cnt = 0;
                was_done = 1'b0;
            end else begin
                if (spur_arm && was_done && dump_bytes == 4) begin
                    tx_done = 1'b1;
                    spur_arm = 1'b0;
                end
                if (uart_cnt > 0) begin
                    uart_cnt--;
                    if (uart_cnt == 0) tx_done = 1'b1;
                end
                was_done = tx_done;
                if (tx_start) begin
                    n_start++;
                    dump_bytes++;
                    check("tx_overlap", uart_cnt, 0);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL tx_byte: got %0h expected no byte", uart_data_out);
                    end else begin
                        check("tx_byte", uart_data_out, exp_q.pop_front());
                    end
                    uart_cnt = 10;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n0, e0, hi, cnt, guard;

        // reset values and reset_mips stretch
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_data", uart_data_out, 0);
        check("rst_addr", dump_addr, 0);
        check("rst_en", mips_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_rmips", reset_mips, 1);
        reset = 1'b0;
        @(negedge clk);
        check("rmips_after_release", reset_mips, 1);
        @(negedge clk);
        check("rmips_released", reset_mips, 0);

        // 'R'
        n0 = n_start;
        send_cmd(8'h52);
        check("r_busy", busy, 1);
        hi = 0;
        repeat (6) begin
            hi += int'(reset_mips);
            @(negedge clk);
        end
        check("r_rmips_cycles", hi, 2);
        check("r_busy_after", busy, 0);
        check("r_no_tx", n_start - n0, 0);

        // 'S' with constant snapshot data
        data_mode = 1'b0;
        push_dump(32'd1);
        n0 = n_start;
        e0 = en_cycles;
        send_cmd(8'h53);
        check("s_busy", busy, 1);
        wait_idle("s_idle");
        check("s_en_cycles", en_cycles - e0, 1);
        check("s_bytes", n_start - n0, 20);
        check("s_q_empty", exp_q.size(), 0);

        // 'C' halted after 7 enabled cycles
        send_cmd(8'h52);
        repeat (3) @(negedge clk);
        data_mode = 1'b1;
        push_dump(32'd7);
        n0 = n_start;
        e0 = en_cycles;
        send_cmd(8'h43);
        cnt = 0;
        guard = 0;
        while (cnt < 7 && guard < 50) begin
            if (mips_enable) cnt++;
            if (cnt == 7) halt = 1'b1;
            else @(negedge clk);
            guard++;
        end
        check("c_en_reached", cnt, 7);
        @(negedge clk);
        check("c_en_drop", mips_enable, 0);
        wait_idle("c_idle");
        halt = 1'b0;
        check("c_en_cycles", en_cycles - e0, 7);
        check("c_bytes", n_start - n0, 20);
        check("c_q_empty", exp_q.size(), 0);

        // 'C' with 'P' and halt in the same cycle
        send_cmd(8'h52);
        repeat (3) @(negedge clk);
        push_dump(32'd5);
        n0 = n_start;
        e0 = en_cycles;
        send_cmd(8'h43);
        cnt = 0;
        guard = 0;
        while (cnt < 5 && guard < 50) begin
            if (mips_enable) cnt++;
            if (cnt < 5) @(negedge clk);
            guard++;
        end
        halt = 1'b1;
        rx_done = 1'b1;
        uart_data_in = 8'h50;
        @(negedge clk);
        rx_done = 1'b0;
        uart_data_in = 8'h00;
        check("p_en_drop", mips_enable, 0);
        wait_idle("p_idle");
        halt = 1'b0;
        check("p_en_cycles", en_cycles - e0, 5);
        check("p_bytes", n_start - n0, 20);
        check("p_q_empty", exp_q.size(), 0);

        // unknown byte in IDLE, then commands and stray tx_done mid-dump
        send_cmd(8'h58);
        check("x_busy", busy, 0);
        check("x_en", mips_enable, 0);
        check("x_rmips", reset_mips, 0);
        push_dump(32'd5);
        dump_bytes = 0;
        spur_arm = 1'b1;
        n0 = n_start;
        e0 = en_cycles;
        send_cmd(8'h44);
        repeat (25) @(negedge clk);
        send_cmd(8'h53);
        repeat (40) @(negedge clk);
        send_cmd(8'h58);
        wait_idle("m_idle");
        check("m_spur_fired", spur_arm, 0);
        check("m_en_cycles", en_cycles - e0, 0);
        check("m_bytes", n_start - n0, 20);
        check("m_q_empty", exp_q.size(), 0);

        // reset in the middle of a dump
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        dump_bytes = 0;
        send_cmd(8'h44);
        guard = 0;
        while (dump_bytes < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("d_three_bytes", dump_bytes, 3);
        reset = 1'b1;
        @(negedge clk);
        check("d_rst_tx_start", tx_start, 0);
        check("d_rst_data", uart_data_out, 0);
        check("d_rst_addr", dump_addr, 0);
        check("d_rst_en", mips_enable, 0);
        check("d_rst_busy", busy, 0);
        check("d_rst_rmips", reset_mips, 1);
        check("d_q_empty", exp_q.size(), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        push_dump(32'd0);
        n0 = n_start;
        send_cmd(8'h44);
        wait_idle("d2_idle");
        check("d2_bytes", n_start - n0, 20);
        check("d2_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
